// File: rtl/axis_frame_rx_pkg.sv
// Shared types and helpers for the AXI4-Stream frame receive buffer.
//   state_e      : receive FSM states
//   CountMax     : saturation ceiling of the 16-bit frame counters
//   popcount()   : number of set bits in a (zero-extended) tkeep vector
//   sat_inc16()  : saturating increment for the frame counters
package axis_frame_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDrop,
        StReady
    } state_e;

    localparam logic [15:0] CountMax = 16'hFFFF;

    // Widest tkeep the helper accepts; callers zero-extend narrower vectors.
    localparam int unsigned MaxKeepWidth = 128;

    function automatic int unsigned popcount(input logic [MaxKeepWidth-1:0] keep);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MaxKeepWidth; i++) begin
            cnt += int'(keep[i]);
        end
        return cnt;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == CountMax) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/axis_frame_rx_buffer_if.sv
// AXI4-Stream bundle feeding the frame receive buffer.
//   tdata/tkeep/tvalid/tlast/tuser : source -> sink
//   tready                          : sink -> source
// Modports: master (stream source), slave (stream sink).
interface axis_frame_rx_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/bsg_mem_1r1w_sync.sv
// One-write one-read synchronous memory.
//   clk_i              : clock
//   w_v_i/w_addr_i/w_data_i : write port, written on the rising edge
//   r_v_i/r_addr_i     : read request, data appears on r_data_o next cycle
//   r_data_o           : registered read data; a same-address write returns old data
module bsg_mem_1r1w_sync #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 512
) (
    input  logic                       clk_i,
    input  logic                       w_v_i,
    input  logic [$clog2(els_p)-1:0]   w_addr_i,
    input  logic [width_p-1:0]         w_data_i,
    input  logic                       r_v_i,
    input  logic [$clog2(els_p)-1:0]   r_addr_i,
    output logic [width_p-1:0]         r_data_o
);
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] r_data_q;

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
        if (r_v_i) begin
            r_data_q <= mem_q[r_addr_i];
        end
    end

    assign r_data_o = r_data_q;
endmodule

// File: rtl/axis_frame_rx_buffer.sv
// AXI4-Stream frame sink with a word-addressed packet buffer.
// Receives one frame at a time, computes its byte length, drops bad or oversize
// frames and presents good frames through a 1-cycle-latency random read port
// until released by frame_ack_i.
//   clk, rst        : single clock, synchronous active-high reset
//   s_axis          : stream input (slave modport)
//   frame_valid_o   : a good frame is held
//   frame_len_o     : byte length of the held frame
//   rd_addr_i       : word read address; rd_data_o follows one cycle later
//   frame_ack_i     : releases the held frame
//   drop_count_o    : saturating count of dropped frames
//   good_count_o    : saturating count of accepted frames
module axis_frame_rx_buffer
    import axis_frame_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned KEEP_WIDTH           = DATA_WIDTH / 8,
    parameter int unsigned DEPTH                = 512,
    parameter logic        USER_BAD_FRAME_VALUE = 1'b1,
    parameter logic        USER_BAD_FRAME_MASK  = 1'b1,
    parameter int unsigned LEN_WIDTH            = $clog2(DEPTH * KEEP_WIDTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_frame_rx_buffer_if.slave      s_axis,
    output logic                       frame_valid_o,
    output logic [LEN_WIDTH-1:0]       frame_len_o,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    input  logic                       frame_ack_i,
    output logic [15:0]                drop_count_o,
    output logic [15:0]                good_count_o
);
    localparam int unsigned AddrWidth = $clog2(DEPTH);

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [15:0]          drop_count_q, drop_count_d;
    logic [15:0]          good_count_q, good_count_d;

    logic                 beat_acc;
    logic                 storing;
    logic                 finalize;
    logic                 frame_bad;
    logic [AddrWidth-1:0] beat_idx;
    logic [LEN_WIDTH-1:0] beat_len;

    assign beat_acc = s_axis.tvalid && s_axis.tready;
    assign storing  = (state_q == StIdle) || (state_q == StRecv);
    assign finalize = beat_acc && storing && s_axis.tlast;

    // The first beat of a frame always lands in word 0, whatever wr_ptr holds.
    assign beat_idx = (state_q == StIdle) ? '0 : wr_ptr_q;

    // Byte length if the current beat were the last one.
    assign beat_len = LEN_WIDTH'(beat_idx) * LEN_WIDTH'(KEEP_WIDTH)
                    + LEN_WIDTH'(popcount(MaxKeepWidth'(s_axis.tkeep)));

    assign frame_bad = ((s_axis.tuser & USER_BAD_FRAME_MASK) ==
                        (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK))
                    || (beat_len == '0);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        len_d        = len_q;
        drop_count_d = drop_count_q;
        good_count_d = good_count_q;

        unique case (state_q)
            StIdle: begin
                if (beat_acc) begin
                    wr_ptr_d = AddrWidth'(1);
                    state_d  = StRecv;
                end
            end
            StRecv: begin
                if (beat_acc) begin
                    wr_ptr_d = wr_ptr_q + AddrWidth'(1);
                    // Buffer is full but the frame continues: discard the rest.
                    if (!s_axis.tlast && wr_ptr_q == AddrWidth'(DEPTH - 1)) begin
                        state_d = StDrop;
                    end
                end
            end
            StDrop: begin
                if (beat_acc && s_axis.tlast) begin
                    drop_count_d = sat_inc16(drop_count_q);
                    state_d      = StIdle;
                end
            end
            StReady: begin
                if (frame_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finalize) begin
            wr_ptr_d = '0;
            if (frame_bad) begin
                drop_count_d = sat_inc16(drop_count_q);
                state_d      = StIdle;
            end else begin
                len_d        = beat_len;
                good_count_d = sat_inc16(good_count_q);
                state_d      = StReady;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            len_q        <= '0;
            drop_count_q <= '0;
            good_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            len_q        <= len_d;
            drop_count_q <= drop_count_d;
            good_count_q <= good_count_d;
        end
    end

    bsg_mem_1r1w_sync #(
        .width_p (DATA_WIDTH),
        .els_p   (DEPTH)
    ) u_mem (
        .clk_i    (clk),
        .w_v_i    (beat_acc && storing),
        .w_addr_i (beat_idx),
        .w_data_i (s_axis.tdata),
        .r_v_i    (1'b1),
        .r_addr_i (rd_addr_i),
        .r_data_o (rd_data_o)
    );

    assign s_axis.tready = (state_q != StReady);
    assign frame_valid_o = (state_q == StReady);
    assign frame_len_o   = len_q;
    assign drop_count_o  = drop_count_q;
    assign good_count_o  = good_count_q;
endmodule

// File: tb/tb_axis_frame_rx_buffer.sv
module tb_axis_frame_rx_buffer;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW = $clog2(DEPTH * KW + 1);
    localparam int BeatBudget = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_ack = 1'b0;
    logic [3:0]    rd_addr = '0;
    logic          frame_valid;
    logic [LW-1:0] frame_len;
    logic [DW-1:0] rd_data;
    logic [15:0]   drop_count;
    logic [15:0]   good_count;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    int          exp_good = 0;
    int          exp_drop = 0;
    logic [31:0] held_q[$];

    always #5 clk = ~clk;

    axis_frame_rx_buffer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis ();

    axis_frame_rx_buffer #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis        (s_axis),
        .frame_valid_o (frame_valid),
        .frame_len_o   (frame_len),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .frame_ack_i   (frame_ack),
        .drop_count_o  (drop_count),
        .good_count_o  (good_count)
    );

    function automatic int ones(input logic [3:0] k);
        return int'(k[0]) + int'(k[1]) + int'(k[2]) + int'(k[3]);
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Drives one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic u);
        bit ok;
        bit acc;
        ok = 1'b0;
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = l;
        s_axis.tuser  = u;
        s_axis.tvalid = 1'b1;
        for (int c = 0; c < BeatBudget; c++) begin
            acc = s_axis.tready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        s_axis.tvalid = 1'b0;
        n_total++;
        if (!ok) $display("FAIL beat_accept: got no tready within %0d cycles, want accept", BeatBudget);
        else n_pass++;
    endtask

    // Sends an nbeats frame and checks the outcome against the model. Leaves a good
    // frame held when do_ack is 0; its words stay in held_q.
    task automatic run_frame(input int nbeats, input logic [3:0] last_keep, input logic user,
                             input bit gaps, input bit do_ack);
        logic [31:0] w;
        bit          good;
        int          len;
        held_q.delete();
        for (int i = 0; i < nbeats; i++) begin
            w = $urandom;
            held_q.push_back(w);
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            if (i == nbeats - 1) send_beat(w, last_keep, 1'b1, user);
            else send_beat(w, 4'hF, 1'b0, 1'($urandom_range(0, 1)));
        end
        // Model: frames over DEPTH words are discarded; otherwise length from beat count.
        len  = (nbeats - 1) * KW + ones(last_keep);
        good = (nbeats <= DEPTH) && !user && (len != 0);
        if (good) exp_good = sat(exp_good + 1);
        else exp_drop = sat(exp_drop + 1);

        n_total++;
        if (frame_valid !== good) $display("FAIL frame_valid: got %0b want %0b", frame_valid, good);
        else n_pass++;
        n_total++;
        if (s_axis.tready !== !good) $display("FAIL tready_after_last: got %0b want %0b", s_axis.tready, !good);
        else n_pass++;
        n_total++;
        if (good_count !== 16'(exp_good)) $display("FAIL good_count: got %0d want %0d", good_count, exp_good);
        else n_pass++;
        n_total++;
        if (drop_count !== 16'(exp_drop)) $display("FAIL drop_count: got %0d want %0d", drop_count, exp_drop);
        else n_pass++;
        if (good) begin
            n_total++;
            if (frame_len !== LW'(len)) $display("FAIL frame_len: got %0d want %0d", frame_len, len);
            else n_pass++;
            for (int a = 0; a < nbeats; a++) begin
                rd_addr = 4'(a);
                @(posedge clk);
                @(negedge clk);
                n_total++;
                if (rd_data !== held_q[a]) $display("FAIL readback[%0d]: got %h want %h", a, rd_data, held_q[a]);
                else n_pass++;
            end
            if (do_ack) begin
                frame_ack = 1'b1;
                @(posedge clk);
                @(negedge clk);
                frame_ack = 1'b0;
                n_total++;
                if (frame_valid !== 1'b0 || s_axis.tready !== 1'b1)
                    $display("FAIL ack_release: got valid=%0b tready=%0b want valid=0 tready=1", frame_valid, s_axis.tready);
                else n_pass++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_good = 0;
        exp_drop = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_total++;
        if (s_axis.tready !== 1'b1 || frame_valid !== 1'b0 || frame_len !== '0 ||
            drop_count !== 16'd0 || good_count !== 16'd0)
            $display("FAIL %s: got tready=%0b valid=%0b len=%0d drop=%0d good=%0d want 1 0 0 0 0",
                     tag, s_axis.tready, frame_valid, frame_len, drop_count, good_count);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset_values");
    endtask

    task automatic test_good_frame();
        run_frame(3, 4'b0011, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (frame_len !== LW'(10)) $display("FAIL good_len10: got %0d want 10", frame_len);
        else n_pass++;
        frame_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_bad_frame();
        run_frame(2, 4'hF, 1'b1, 1'b0, 1'b1);
        run_frame(3, 4'b0111, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_oversize();
        run_frame(20, 4'hF, 1'b0, 1'b0, 1'b1);
        run_frame(16, 4'hF, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (frame_len !== LW'(64)) $display("FAIL full_len64: got %0d want 64", frame_len);
        else n_pass++;
        frame_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] nw;
        run_frame(4, 4'hF, 1'b0, 1'b0, 1'b0);
        nw = $urandom;
        s_axis.tdata  = nw;
        s_axis.tkeep  = 4'hF;
        s_axis.tlast  = 1'b1;
        s_axis.tuser  = 1'b0;
        s_axis.tvalid = 1'b1;
        // Second frame offered while held: stalled, held data intact.
        for (int a = 0; a < 4; a++) begin
            rd_addr = 4'(a);
            n_total++;
            if (s_axis.tready !== 1'b0) $display("FAIL stall_tready: got %0b want 0", s_axis.tready);
            else n_pass++;
            @(posedge clk);
            @(negedge clk);
            n_total++;
            if (rd_data !== held_q[a]) $display("FAIL held_intact[%0d]: got %h want %h", a, rd_data, held_q[a]);
            else n_pass++;
        end
        frame_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_ack = 1'b0;
        n_total++;
        if (s_axis.tready !== 1'b1 || frame_valid !== 1'b0)
            $display("FAIL ack_next_cycle: got tready=%0b valid=%0b want 1 0", s_axis.tready, frame_valid);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        exp_good = sat(exp_good + 1);
        n_total++;
        if (frame_valid !== 1'b1 || frame_len !== LW'(4) || good_count !== 16'(exp_good))
            $display("FAIL accept_n_plus_1: got valid=%0b len=%0d good=%0d want 1 4 %0d",
                     frame_valid, frame_len, good_count, exp_good);
        else n_pass++;
        rd_addr = 4'd0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (rd_data !== nw) $display("FAIL new_word0: got %h want %h", rd_data, nw);
        else n_pass++;
        frame_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_edge_inputs();
        run_frame(1, 4'b0000, 1'b0, 1'b0, 1'b1);
        // Interrupted frame: two beats in, then reset.
        send_beat($urandom, 4'hF, 1'b0, 1'b0);
        send_beat($urandom, 4'hF, 1'b0, 1'b0);
        do_reset();
        check_reset_outputs("reset_mid_frame");
        // Remaining beats form a new frame.
        run_frame(2, 4'b0001, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] keeps [5];
        keeps[0] = 4'b0000; keeps[1] = 4'b0001; keeps[2] = 4'b0011;
        keeps[3] = 4'b0111; keeps[4] = 4'b1111;
        for (int f = 0; f < 24; f++) begin
            run_frame(int'($urandom_range(1, 20)), keeps[$urandom_range(0, 4)],
                      1'($urandom_range(0, 3) == 0), 1'b1, 1'b1);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.good_count_q = 16'hFFFE;
        #1;
        release dut.good_count_q;
        exp_good = 65534;
        for (int f = 0; f < 3; f++) run_frame(2, 4'hF, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (good_count !== 16'hFFFF) $display("FAIL good_saturate: got %h want ffff", good_count);
        else n_pass++;
    endtask

    initial begin
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = 1'b0;
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_oversize();
        test_back_to_back();
        test_edge_inputs();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
